// File: rtl/tdm_mux.sv
// tdm_mux: registered N:1 multiplexer with a valid/ready output stage.
// Channels are selected either by an external index (manual) or by a
// round-robin scan over requesting channels starting at a rotating pointer.
module tdm_mux #(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 1,
    parameter int unsigned SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     y,
    output logic                 y_valid,
    output logic [SELW-1:0]      y_ch
);

    logic [WIDTH-1:0] r_y;
    logic [SELW-1:0]  r_y_ch;
    logic             r_y_valid;
    logic [SELW-1:0]  r_ptr;

    logic             w_load_ok;
    logic             w_grant;
    logic [SELW-1:0]  w_g;
    logic [WIDTH-1:0] w_data;
    logic [SELW-1:0]  w_ptr_next;

    assign w_load_ok = !r_y_valid || out_ready;

    // Grant selection: manual index or first requester at/after the scan pointer.
    always_comb begin
        int idx;
        w_grant = 1'b0;
        w_g     = '0;
        idx     = 0;
        // Reset also holds in_ready low, so nothing is acknowledged then.
        if (w_load_ok && !rst) begin
            if (!mode) begin
                // sel values >= N match no channel and therefore never grant.
                for (int i = 0; i < N; i++) begin
                    if (sel == SELW'(i) && in_valid[i]) begin
                        w_grant = 1'b1;
                        w_g     = SELW'(i);
                    end
                end
            end else begin
                // Search offsets 0..N-1 from the pointer, wrapping at N.
                for (int k = 0; k < N; k++) begin
                    idx = int'(r_ptr) + k;
                    if (idx >= int'(N)) begin
                        idx = idx - int'(N);
                    end
                    for (int i = 0; i < N; i++) begin
                        if (!w_grant && idx == i && in_valid[i]) begin
                            w_grant = 1'b1;
                            w_g     = SELW'(i);
                        end
                    end
                end
            end
        end
    end

    // One-hot acknowledge and data select for the granted channel.
    always_comb begin
        in_ready = '0;
        w_data   = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant && w_g == SELW'(i)) begin
                in_ready[i] = 1'b1;
                w_data      = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Pointer advances to the channel after the grant, wrapping at N.
    always_comb begin
        if (w_g == SELW'(N - 1)) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = w_g + SELW'(1);
        end
    end

    // Output register and scan pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y       <= '0;
            r_y_ch    <= '0;
            r_y_valid <= 1'b0;
            r_ptr     <= '0;
        end else begin
            if (w_grant) begin
                r_y       <= w_data;
                r_y_ch    <= w_g;
                r_y_valid <= 1'b1;
                if (mode) begin
                    r_ptr <= w_ptr_next;
                end
            end else if (out_ready) begin
                r_y_valid <= 1'b0;
            end
        end
    end

    assign y       = r_y;
    assign y_ch    = r_y_ch;
    assign y_valid = r_y_valid;

endmodule

// File: tb/tb_tdm_mux.sv
// Directed, table-driven bench for tdm_mux (N=4 main instance, N=3 instance
// for the out-of-range select case).
module tb_tdm_mux;

    logic        clk;
    logic        rst;

    // N=4, WIDTH=8 instance
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        out_ready;
    logic [7:0]  y;
    logic        y_valid;
    logic [1:0]  y_ch;

    // N=3, WIDTH=8 instance
    logic        mode3;
    logic [1:0]  sel3;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic        out_ready3;
    logic [7:0]  y3;
    logic        y_valid3;
    logic [1:0]  y_ch3;

    int n_tests;
    int n_fail;

    tdm_mux #(.N(4), .WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .y         (y),
        .y_valid   (y_valid),
        .y_ch      (y_ch)
    );

    tdm_mux #(.N(3), .WIDTH(8)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode3),
        .sel       (sel3),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .out_ready (out_ready3),
        .y         (y3),
        .y_valid   (y_valid3),
        .y_ch      (y_ch3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] e_ir;
        logic [7:0] e_y;
        logic [1:0] e_ch;
        logic       e_v;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic m, logic [1:0] s, logic [3:0] v, logic o,
                                logic [3:0] ir, logic [7:0] ey, logic [1:0] ch,
                                logic ev);
        vec_t r;
        r.mode = m; r.sel = s; r.vld = v; r.ordy = o;
        r.e_ir = ir; r.e_y = ey; r.e_ch = ch; r.e_v = ev;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        in_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        in_data3 = {8'h33, 8'h22, 8'h11};
        mode = 1'b0; sel = 2'd0; in_valid = 4'b0000; out_ready = 1'b1;
        mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b000; out_ready3 = 1'b1;

        // mode sel valid ordy | in_ready y ch valid (after edge)
        // Manual stepping
        vq.push_back(mk(1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 8'hA0, 2'd0, 1'b1));
        vq.push_back(mk(1'b0, 2'd1, 4'b1111, 1'b1, 4'b0010, 8'hB1, 2'd1, 1'b1));
        vq.push_back(mk(1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 8'hC2, 2'd2, 1'b1));
        vq.push_back(mk(1'b0, 2'd3, 4'b1111, 1'b1, 4'b1000, 8'hD3, 2'd3, 1'b1));
        // Scan fairness, ptr starts at 0
        for (int r = 0; r < 2; r++) begin
            vq.push_back(mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 8'hA0, 2'd0, 1'b1));
            vq.push_back(mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 8'hB1, 2'd1, 1'b1));
            vq.push_back(mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 8'hC2, 2'd2, 1'b1));
            vq.push_back(mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 8'hD3, 2'd3, 1'b1));
        end
        // Move ptr to 2, then skip/wrap with 0011
        vq.push_back(mk(1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, 8'hB1, 2'd1, 1'b1));
        vq.push_back(mk(1'b1, 2'd0, 4'b0011, 1'b1, 4'b0001, 8'hA0, 2'd0, 1'b1));
        vq.push_back(mk(1'b1, 2'd0, 4'b0011, 1'b1, 4'b0010, 8'hB1, 2'd1, 1'b1));
        vq.push_back(mk(1'b1, 2'd0, 4'b0011, 1'b1, 4'b0001, 8'hA0, 2'd0, 1'b1));
        // Backpressure three cycles (ptr=1), then release loads ch1 with no bubble
        for (int r = 0; r < 3; r++) begin
            vq.push_back(mk(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 8'hA0, 2'd0, 1'b1));
        end
        vq.push_back(mk(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 8'hB1, 2'd1, 1'b1));
        // Drain with no requests; y/y_ch hold
        vq.push_back(mk(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 8'hB1, 2'd1, 1'b0));
        vq.push_back(mk(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 8'hB1, 2'd1, 1'b0));
        // Manual select of a channel that is not valid
        vq.push_back(mk(1'b0, 2'd2, 4'b1011, 1'b1, 4'b0000, 8'hB1, 2'd1, 1'b0));
        // Empty slot loads even with out_ready low, then holds
        vq.push_back(mk(1'b0, 2'd2, 4'b0100, 1'b0, 4'b0100, 8'hC2, 2'd2, 1'b1));
        vq.push_back(mk(1'b0, 2'd2, 4'b0100, 1'b0, 4'b0000, 8'hC2, 2'd2, 1'b1));

        // Reset state
        rst = 1'b1;
        #3;
        check("rst_y", int'(y), 0);
        check("rst_y_valid", int'(y_valid), 0);
        check("rst_y_ch", int'(y_ch), 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vq[i]) begin
            if (i != 0) @(negedge clk);
            mode = vq[i].mode; sel = vq[i].sel;
            in_valid = vq[i].vld; out_ready = vq[i].ordy;
            #1;
            check($sformatf("v%0d_in_ready", i), int'(in_ready), int'(vq[i].e_ir));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_y", i), int'(y), int'(vq[i].e_y));
            check($sformatf("v%0d_y_ch", i), int'(y_ch), int'(vq[i].e_ch));
            check($sformatf("v%0d_y_valid", i), int'(y_valid), int'(vq[i].e_v));
        end

        // Mid-cycle asynchronous reset while a word is held (ptr is 2 here)
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_y", int'(y), 0);
        check("async_rst_y_ch", int'(y_ch), 0);
        check("async_rst_y_valid", int'(y_valid), 0);
        check("async_rst_in_ready", int'(in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", int'(in_ready), 4'b0001);
        @(posedge clk);
        #1;
        check("post_rst_y_ch", int'(y_ch), 0);
        check("post_rst_y", int'(y), 8'hA0);
        check("post_rst_y_valid", int'(y_valid), 1);

        // N=3: load a word, then sel=3 never grants and the word drains
        @(negedge clk);
        in_valid = 4'b0000;
        mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b111; out_ready3 = 1'b0;
        #1;
        check("n3_load_in_ready", int'(in_ready3), 3'b001);
        @(posedge clk);
        #1;
        check("n3_load_y", int'(y3), 8'h11);
        check("n3_load_y_valid", int'(y_valid3), 1);
        @(negedge clk);
        sel3 = 2'd3; out_ready3 = 1'b1;
        #1;
        check("n3_sel3_in_ready_a", int'(in_ready3), 0);
        @(posedge clk);
        #1;
        check("n3_drain_y_valid", int'(y_valid3), 0);
        @(negedge clk);
        #1;
        check("n3_sel3_in_ready_b", int'(in_ready3), 0);
        @(posedge clk);
        #1;
        check("n3_idle_y_valid", int'(y_valid3), 0);
        check("n3_idle_y_hold", int'(y3), 8'h11);
        check("n3_idle_y_ch_hold", int'(y_ch3), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
